// File: rtl/odo_pkg.sv
// Shared definitions for the Odo round-key scheduler.
// Holds default geometry, the sweep FSM encoding and the Odo default key constants
// that benches and boot firmware load into the scheduler.
package odo_pkg;

    localparam int unsigned OdoKeyW    = 10;
    localparam int unsigned OdoPeriods = 9;
    localparam int unsigned OdoPeriodW = 4;
    localparam int unsigned OdoLanes   = 8;
    localparam int unsigned OdoLaneW   = 3;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } odo_state_e;

    // Default lane-0 epoch constants for the first three periods; other entries boot as 0.
    function automatic logic [OdoKeyW-1:0] odo_default_key(input int unsigned period);
        logic [OdoKeyW-1:0] key;
        case (period)
            0:       key = 10'h2f8;
            1:       key = 10'h290;
            2:       key = 10'h2cb;
            default: key = '0;
        endcase
        return key;
    endfunction

endpackage

// File: rtl/odo_key_bank.sv
// One LANES x PERIODS x KEY_W round-key register bank.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset (clears every entry)
//   we, wr_lane, wr_period  write strobe and address (caller guarantees range)
//   wr_data                 key value written at the clock edge
//   rd_a_period/rd_a_keys   asynchronous read of one period, all lanes (sweep port)
//   rd_b_period/rd_b_keys   asynchronous read of one period, all lanes (lookup port)
// Out-of-range read periods return 0.
module odo_key_bank
    import odo_pkg::*;
#(
    parameter int unsigned KEY_W    = OdoKeyW,
    parameter int unsigned PERIODS  = OdoPeriods,
    parameter int unsigned PERIOD_W = OdoPeriodW,
    parameter int unsigned LANES    = OdoLanes,
    parameter int unsigned LANE_W   = OdoLaneW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [LANE_W-1:0]      wr_lane,
    input  logic [PERIOD_W-1:0]    wr_period,
    input  logic [KEY_W-1:0]       wr_data,
    input  logic [PERIOD_W-1:0]    rd_a_period,
    output logic [LANES*KEY_W-1:0] rd_a_keys,
    input  logic [PERIOD_W-1:0]    rd_b_period,
    output logic [LANES*KEY_W-1:0] rd_b_keys
);

    localparam logic [PERIOD_W-1:0] LastPeriod = PERIOD_W'(PERIODS - 1);

    logic [KEY_W-1:0] mem_q [LANES][PERIODS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < int'(LANES); l++) begin
                for (int p = 0; p < int'(PERIODS); p++) begin
                    mem_q[l][p] <= '0;
                end
            end
        end else if (we) begin
            mem_q[wr_lane][wr_period] <= wr_data;
        end
    end

    always_comb begin
        rd_a_keys = '0;
        rd_b_keys = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            if (rd_a_period <= LastPeriod) begin
                rd_a_keys[l*KEY_W +: KEY_W] = mem_q[l][rd_a_period];
            end
            if (rd_b_period <= LastPeriod) begin
                rd_b_keys[l*KEY_W +: KEY_W] = mem_q[l][rd_b_period];
            end
        end
    end

endmodule

// File: rtl/odo_round_key_sched.sv
// Double-buffered, run-time-loadable round-key scheduler for the Odo hash core.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   wr_en/wr_lane/wr_period/wr_data  shadow-bank write; wr_err pulses for a dropped write
//   commit, commit_pending, bank_sel bank swap request, queued-swap flag, active bank index
//   start, busy                    sweep launch (IDLE only) and sweep-in-progress flag
//   out_valid/out_ready            per-period key vector handshake
//   out_period/out_keys/out_last   current beat: period index, all lane keys, final-beat flag
//   lk_period, lk_keys             registered random-access lookup into the active bank
module odo_round_key_sched
    import odo_pkg::*;
#(
    parameter int unsigned KEY_W    = OdoKeyW,
    parameter int unsigned PERIODS  = OdoPeriods,
    parameter int unsigned PERIOD_W = OdoPeriodW,
    parameter int unsigned LANES    = OdoLanes,
    parameter int unsigned LANE_W   = OdoLaneW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [LANE_W-1:0]      wr_lane,
    input  logic [PERIOD_W-1:0]    wr_period,
    input  logic [KEY_W-1:0]       wr_data,
    output logic                   wr_err,
    input  logic                   commit,
    output logic                   commit_pending,
    output logic                   bank_sel,
    input  logic                   start,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PERIOD_W-1:0]    out_period,
    output logic [LANES*KEY_W-1:0] out_keys,
    output logic                   out_last,
    input  logic [PERIOD_W-1:0]    lk_period,
    output logic [LANES*KEY_W-1:0] lk_keys
);

    localparam logic [PERIOD_W-1:0] LastPeriod = PERIOD_W'(PERIODS - 1);

    odo_state_e             state_q, state_d;
    logic                   bank_sel_q, bank_sel_d;
    logic                   pend_q, pend_d;
    logic [PERIOD_W-1:0]    period_q, period_d;
    logic [LANES*KEY_W-1:0] keys_q, keys_d;
    logic [LANES*KEY_W-1:0] lk_q, lk_d;
    logic                   wr_err_q;
    logic                   load_keys;

    logic                   lane_ok, wr_ok;
    logic [1:0]             bank_we;
    logic [LANES*KEY_W-1:0] sweep_rd [2];
    logic [LANES*KEY_W-1:0] lk_rd [2];

    // A lane index that spans its full encoding is always in range.
    if ((2 ** LANE_W) == LANES) begin : g_lane_full
        assign lane_ok = 1'b1;
    end else begin : g_lane_chk
        assign lane_ok = (wr_lane <= LANE_W'(LANES - 1));
    end

    assign wr_ok = wr_en & lane_ok & (wr_period <= LastPeriod);

    // Writes always target the shadow bank as seen before the edge.
    assign bank_we[0] = wr_ok & bank_sel_q;
    assign bank_we[1] = wr_ok & ~bank_sel_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        odo_key_bank #(
            .KEY_W   (KEY_W),
            .PERIODS (PERIODS),
            .PERIOD_W(PERIOD_W),
            .LANES   (LANES),
            .LANE_W  (LANE_W)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .we         (bank_we[b]),
            .wr_lane    (wr_lane),
            .wr_period  (wr_period),
            .wr_data    (wr_data),
            .rd_a_period(period_d),
            .rd_a_keys  (sweep_rd[b]),
            .rd_b_period(lk_period),
            .rd_b_keys  (lk_rd[b])
        );
    end

    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        pend_d     = pend_q;
        period_d   = period_q;
        load_keys  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (commit) begin
                    bank_sel_d = ~bank_sel_q;
                end
                if (start) begin
                    state_d   = StRun;
                    period_d  = '0;
                    load_keys = 1'b1;
                end
            end
            StRun: begin
                if (out_ready) begin
                    if (period_q == LastPeriod) begin
                        state_d  = StIdle;
                        period_d = '0;
                        pend_d   = 1'b0;
                        if (pend_q | commit) begin
                            bank_sel_d = ~bank_sel_q;
                        end
                    end else begin
                        period_d  = period_q + 1'b1;
                        load_keys = 1'b1;
                        pend_d    = pend_q | commit;
                    end
                end else begin
                    pend_d = pend_q | commit;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Keys are fetched from the bank that is active after the edge; they clear on sweep exit.
    always_comb begin
        keys_d = keys_q;
        if (load_keys) begin
            keys_d = sweep_rd[bank_sel_d];
        end else if (state_d == StIdle) begin
            keys_d = '0;
        end
    end

    // Undefined lookup indices hold the previous result, like the legacy ROM.
    always_comb begin
        lk_d = lk_q;
        if (lk_period <= LastPeriod) begin
            lk_d = lk_rd[bank_sel_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bank_sel_q <= 1'b0;
            pend_q     <= 1'b0;
            period_q   <= '0;
            keys_q     <= '0;
            lk_q       <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            pend_q     <= pend_d;
            period_q   <= period_d;
            keys_q     <= keys_d;
            lk_q       <= lk_d;
            wr_err_q   <= wr_en & ~wr_ok;
        end
    end

    assign busy           = (state_q == StRun);
    assign out_valid      = (state_q == StRun);
    assign out_period     = period_q;
    assign out_keys       = keys_q;
    assign out_last       = (state_q == StRun) && (period_q == LastPeriod);
    assign commit_pending = pend_q;
    assign bank_sel       = bank_sel_q;
    assign lk_keys        = lk_q;
    assign wr_err         = wr_err_q;

endmodule

// File: tb/tb_odo_round_key_sched.sv
// Self-checking bench for odo_round_key_sched: directed scenarios followed by random traffic,
// every cycle compared against a table-level reference model of the scheduler.
module tb_odo_round_key_sched;
    import odo_pkg::*;

    localparam int KW = 10;
    localparam int NP = 9;
    localparam int NL = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_en = 1'b0;
    logic [2:0]     wr_lane = '0;
    logic [3:0]     wr_period = '0;
    logic [KW-1:0]  wr_data = '0;
    logic           wr_err;
    logic           commit = 1'b0;
    logic           commit_pending;
    logic           bank_sel;
    logic           start = 1'b0;
    logic           busy;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [3:0]     out_period;
    logic [NL*KW-1:0] out_keys;
    logic           out_last;
    logic [3:0]     lk_period = '0;
    logic [NL*KW-1:0] lk_keys;

    always #5 clk = ~clk;

    odo_round_key_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_lane       (wr_lane),
        .wr_period     (wr_period),
        .wr_data       (wr_data),
        .wr_err        (wr_err),
        .commit        (commit),
        .commit_pending(commit_pending),
        .bank_sel      (bank_sel),
        .start         (start),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_period    (out_period),
        .out_keys      (out_keys),
        .out_last      (out_last),
        .lk_period     (lk_period),
        .lk_keys       (lk_keys)
    );

    // Reference model: two key tables, the active index, and the sweep position.
    logic [KW-1:0]    mbank [2][NL][NP];
    bit               msel, mrun, mpend, merr;
    int               mper;
    logic [NL*KW-1:0] mlk;

    int n_checks = 0;
    int n_pass = 0;

    function automatic logic [NL*KW-1:0] row(input bit b, input int p);
        logic [NL*KW-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[i*KW +: KW] = mbank[b][i][p];
        return r;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int l = 0; l < NL; l++)
                for (int p = 0; p < NP; p++) mbank[b][l][p] = '0;
        msel = 0; mrun = 0; mpend = 0; merr = 0; mper = 0; mlk = '0;
    endtask

    // Apply the rules for one clock edge using the inputs present before it.
    task automatic model_edge();
        bit old_sel;
        bit ok;
        old_sel = msel;
        ok = wr_en && (int'(wr_lane) < NL) && (int'(wr_period) < NP);
        merr = wr_en && !ok;
        if (!mrun) begin
            if (commit) msel = !msel;
            if (start) begin
                mrun = 1;
                mper = 0;
            end
        end else if (out_ready) begin
            if (mper == NP - 1) begin
                mrun = 0;
                mper = 0;
                if (mpend || commit) msel = !msel;
                mpend = 0;
            end else begin
                mper++;
                mpend = mpend || commit;
            end
        end else begin
            mpend = mpend || commit;
        end
        if (int'(lk_period) < NP) mlk = row(msel, int'(lk_period));
        if (ok) mbank[!old_sel][wr_lane][wr_period] = wr_data;
    endtask

    task automatic chk(input string tag, input logic [NL*KW-1:0] obs,
                       input logic [NL*KW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("out_valid", 80'(out_valid), 80'(mrun));
        chk("busy", 80'(busy), 80'(mrun));
        chk("out_period", 80'(out_period), 80'(mper));
        chk("out_keys", out_keys, mrun ? row(msel, mper) : '0);
        chk("out_last", 80'(out_last), 80'(mrun && mper == NP - 1));
        chk("wr_err", 80'(wr_err), 80'(merr));
        chk("commit_pending", 80'(commit_pending), 80'(mpend));
        chk("bank_sel", 80'(bank_sel), 80'(msel));
        chk("lk_keys", lk_keys, mlk);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic finish_sweep();
        out_ready = 1'b1;
        for (int k = 0; k < 40 && mrun; k++) cyc();
        chk("sweep_done", 80'(busy), 80'(0));
    endtask

    task automatic begin_sweep();
        start = 1'b1;
        out_ready = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep of an unloaded table: nine zero beats.
        begin_sweep();
        chk("first_period", 80'(out_period), 80'(0));
        finish_sweep();

        // Load lane 0 defaults, commit in IDLE, sweep.
        for (int p = 0; p < 3; p++) begin
            wr_en = 1'b1;
            wr_lane = 3'd0;
            wr_period = 4'(p);
            wr_data = odo_default_key(p);
            cyc();
        end
        wr_en = 1'b0;
        commit = 1'b1;
        cyc();
        commit = 1'b0;
        chk("bank_sel_after_commit", 80'(bank_sel), 80'(1));
        begin_sweep();
        chk("lane0_p0", 80'(out_keys[0 +: KW]), 80'(10'h2f8));
        cyc();
        chk("lane0_p1", 80'(out_keys[0 +: KW]), 80'(10'h290));
        cyc();
        chk("lane0_p2", 80'(out_keys[0 +: KW]), 80'(10'h2cb));
        finish_sweep();

        // Backpressure at period 4.
        begin_sweep();
        for (int k = 0; k < 20 && mper != 4; k++) cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        chk("bp_period", 80'(out_period), 80'(4));
        finish_sweep();

        // Mid-sweep update of lane 7 period 8 with a queued commit.
        begin_sweep();
        cyc();
        cyc();
        wr_en = 1'b1;
        wr_lane = 3'd7;
        wr_period = 4'd8;
        wr_data = 10'h10d;
        commit = 1'b1;
        cyc();
        wr_en = 1'b0;
        commit = 1'b0;
        chk("pending_set", 80'(commit_pending), 80'(1));
        for (int k = 0; k < 20 && mper != NP - 1; k++) cyc();
        chk("old_lane7_p8", 80'(out_keys[7*KW +: KW]), 80'(10'h000));
        finish_sweep();
        chk("pending_clear", 80'(commit_pending), 80'(0));
        begin_sweep();
        for (int k = 0; k < 20 && mper != NP - 1; k++) cyc();
        chk("new_lane7_p8", 80'(out_keys[7*KW +: KW]), 80'(10'h10d));
        finish_sweep();

        // Out-of-range writes and lookups.
        wr_en = 1'b1;
        wr_lane = 3'd1;
        wr_period = 4'd9;
        wr_data = 10'h3ff;
        cyc();
        wr_en = 1'b0;
        chk("wr_err_pulse", 80'(wr_err), 80'(1));
        cyc();
        chk("wr_err_clear", 80'(wr_err), 80'(0));
        wr_en = 1'b1;
        wr_period = 4'd15;
        cyc();
        wr_en = 1'b0;
        cyc();
        lk_period = 4'd8;
        cyc();
        chk("lk_p8", 80'(lk_keys[7*KW +: KW]), 80'(10'h10d));
        lk_period = 4'd12;
        cyc();
        cyc();
        chk("lk_hold", 80'(lk_keys[7*KW +: KW]), 80'(10'h10d));

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            wr_en = ($urandom_range(0, 2) == 0);
            wr_lane = 3'($urandom_range(0, 7));
            wr_period = 4'($urandom_range(0, 10));
            wr_data = 10'($urandom);
            commit = ($urandom_range(0, 15) == 0);
            start = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            lk_period = 4'($urandom_range(0, 11));
            // Skip a write that coincides with a swap that also launches a sweep.
            if (!mrun && start && commit) wr_en = 1'b0;
            cyc();
        end
        wr_en = 1'b0;
        commit = 1'b0;
        start = 1'b0;
        finish_sweep();

        // Asynchronous reset in the middle of a sweep.
        commit = 1'b1;
        begin_sweep();
        commit = 1'b0;
        wr_en = 1'b1;
        wr_lane = 3'd2;
        wr_period = 4'd6;
        wr_data = 10'h155;
        cyc();
        wr_en = 1'b0;
        commit = 1'b1;
        for (int k = 0; k < 20 && mper != 5; k++) cyc();
        commit = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        lk_period = 4'd6;
        begin_sweep();
        finish_sweep();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
